// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, WIDTH iterations.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
`endif

  logic             accept;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;
  logic [WIDTH-1:0] load_dvd;
  logic [WIDTH-1:0] load_dvs;

  // Datapath: the dividend register doubles as the quotient shift register.
  always_comb begin
    accept   = start && (state_q != S_RUN);
    trial    = {prem_q, dvd_q[WIDTH-1]};
    diff     = trial - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH];
    step_rem = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], qbit};
`ifdef SEQ_DIVIDER_SIGNED_EN
    fin_quo  = negq_q ? (-step_quo) : step_quo;
    fin_rem  = negr_q ? (-step_rem) : step_rem;
    load_dvd = dividend[WIDTH-1] ? (-dividend) : dividend;
    load_dvs = divisor[WIDTH-1]  ? (-divisor)  : divisor;
`else
    fin_quo  = step_quo;
    fin_rem  = step_rem;
    load_dvd = dividend;
    load_dvs = divisor;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      S_RUN: begin
        prem_d = step_rem;
        dvd_d  = step_quo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = fin_quo;
          rmd_d   = fin_rem;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          dvd_d  = load_dvd;
          dvs_d  = load_dvs;
          prem_d = '0;
          cnt_d  = CNT_LOAD;
`ifdef SEQ_DIVIDER_SIGNED_EN
          negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negr_d = dividend[WIDTH-1];
`endif
          if (divisor != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            // Zero divisor completes immediately with the raw dividend as remainder.
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=16.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int bcnt;
  int dcnt;

  seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request so it is sampled at the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Counts edges from the accept edge (=1) until done; bounded.
  task automatic wait_done(input int lat0, output int l, output int bc);
    l  = lat0;
    bc = 0;
    while (!done && l < 64) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quo", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100 / 7
    issue(16'd100, 16'd7);
    wait_done(1, lat, bcnt);
    check("d100_lat", 32'(lat), 32'd17);
    check("d100_busycnt", 32'(bcnt), 32'd16);
    check("d100_busy_at_done", 32'(busy), 32'd0);
    check("d100_quo", 32'(quotient), 32'd14);
    check("d100_rem", 32'(remainder), 32'd2);
    check("d100_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    check("d100_done_pulse", 32'(done), 32'd0);
    check("d100_quo_held", 32'(quotient), 32'd14);

    // 1234 / 0
    issue(16'd1234, 16'd0);
    check("dz_done", 32'(done), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_quo", 32'(quotient), 32'hFFFF);
    check("dz_rem", 32'(remainder), 32'd1234);
    check("dz_dbz", 32'(div_by_zero), 32'd1);
    @(posedge clk);
    #1;
    check("dz_done_drop", 32'(done), 32'd0);
    check("dz_dbz_held", 32'(div_by_zero), 32'd1);

    // 0xFFFF / 1 then back-to-back 5 / 9 issued in the DONE cycle
    issue(16'hFFFF, 16'd1);
    wait_done(1, lat, bcnt);
    check("ff_lat", 32'(lat), 32'd17);
    check("ff_quo", 32'(quotient), 32'hFFFF);
    check("ff_rem", 32'(remainder), 32'd0);
    check("ff_dbz_cleared", 32'(div_by_zero), 32'd0);
    issue(16'd5, 16'd9);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_quo_held", 32'(quotient), 32'hFFFF);
    wait_done(1, lat, bcnt);
    check("b2b_lat", 32'(lat), 32'd17);
    check("b2b_quo", 32'(quotient), 32'd0);
    check("b2b_rem", 32'(remainder), 32'd5);

    // 200 / 10 with an ignored 50 / 3 request mid-RUN
    issue(16'd200, 16'd10);
    repeat (4) @(posedge clk);
    #1;
    issue(16'd50, 16'd3);
    wait_done(6, lat, bcnt);
    check("ign_lat", 32'(lat), 32'd17);
    check("ign_quo", 32'(quotient), 32'd20);
    check("ign_rem", 32'(remainder), 32'd0);
    @(posedge clk);
    #1;
    check("ign_no_second_done", 32'(done), 32'd0);
    check("ign_not_busy", 32'(busy), 32'd0);

    // Reset asserted in RUN cycle 8 of 1000 / 3
    issue(16'd1000, 16'd3);
    repeat (7) @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_quo", 32'(quotient), 32'd0);
    check("mid_rem", 32'(remainder), 32'd0);
    check("mid_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("mid_no_done", 32'(dcnt), 32'd0);
    issue(16'd9, 16'd4);
    wait_done(1, lat, bcnt);
    check("post_lat", 32'(lat), 32'd17);
    check("post_quo", 32'(quotient), 32'd2);
    check("post_rem", 32'(remainder), 32'd1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(16'hFFF9, 16'd2);
    wait_done(1, lat, bcnt);
    check("s_m7_lat", 32'(lat), 32'd17);
    check("s_m7_quo", 32'(quotient), 32'hFFFD);
    check("s_m7_rem", 32'(remainder), 32'hFFFF);
    issue(16'h8000, 16'hFFFF);
    wait_done(1, lat, bcnt);
    check("s_min_lat", 32'(lat), 32'd17);
    check("s_min_quo", 32'(quotient), 32'h8000);
    check("s_min_rem", 32'(remainder), 32'd0);
    check("s_min_dbz", 32'(div_by_zero), 32'd0);
    issue(16'd7, 16'hFFFE);
    wait_done(1, lat, bcnt);
    check("s_7m2_quo", 32'(quotient), 32'hFFFD);
    check("s_7m2_rem", 32'(remainder), 32'd1);
`else
    issue(16'hFFFF, 16'hFFFF);
    wait_done(1, lat, bcnt);
    check("u_max_quo", 32'(quotient), 32'd1);
    check("u_max_rem", 32'(remainder), 32'd0);
    issue(16'h8000, 16'hFFFF);
    wait_done(1, lat, bcnt);
    check("u_big_quo", 32'(quotient), 32'd0);
    check("u_big_rem", 32'(remainder), 32'h8000);
    issue(16'd0, 16'd5);
    wait_done(1, lat, bcnt);
    check("u_zero_lat", 32'(lat), 32'd17);
    check("u_zero_quo", 32'(quotient), 32'd0);
    check("u_zero_rem", 32'(remainder), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
